// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial adder controller and its datapath.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Operand, datapath and result signals of the serial adder controller.
interface serial_add_ctrl_if
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] dp_a;
   logic [WIDTH-1:0] dp_b;
   logic             dp_pipo;
   logic             dp_shift;
   logic             dp_cclr;
   logic             dp_sum;
   logic             dp_cout;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_sum;
   logic             out_cout;
   logic             busy;

   // Controller side
   modport master (
      input  in_valid, in_a, in_b, dp_sum, dp_cout, out_ready,
      output in_ready, dp_a, dp_b, dp_pipo, dp_shift, dp_cclr,
             out_valid, out_sum, out_cout, busy
   );

   // Producer, consumer and datapath side
   modport slave (
      output in_valid, in_a, in_b, dp_sum, dp_cout, out_ready,
      input  in_ready, dp_a, dp_b, dp_pipo, dp_shift, dp_cclr,
             out_valid, out_sum, out_cout, busy
   );

endinterface

// File: rtl/serial_add_ctrl_sum_deser.sv
// Right-shift deserialiser: LSB-first bits enter at the MSB and settle in place.
module sum_deser #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             din,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         q <= '0;
      end else if (en) begin
         q <= {din, q[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/serial_add_ctrl.sv
// Sequencer for the bit-serial adder: loads operands, strobes WIDTH shifts,
// collects the sum bits and hands the result to the consumer.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input logic               clk,
   input logic               clr,
   serial_add_ctrl_if.master bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic             pipo;
   logic             shift;
   logic             cclr;
   logic             valid;
   logic             cout_q;
   logic             idle;
   logic [WIDTH-1:0] sum_q;

   // A result leaving DONE frees the controller on the same edge
   assign bus.in_ready  = idle | (valid & bus.out_ready);
   assign bus.dp_a      = a_q;
   assign bus.dp_b      = b_q;
   assign bus.dp_pipo   = pipo;
   assign bus.dp_shift  = shift;
   assign bus.dp_cclr   = cclr;
   assign bus.out_valid = valid;
   assign bus.out_sum   = sum_q;
   assign bus.out_cout  = cout_q;
   assign bus.busy      = ~idle;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state  <= IDLE;
         cnt    <= '0;
         a_q    <= '0;
         b_q    <= '0;
         pipo   <= 1'b0;
         shift  <= 1'b0;
         cclr   <= 1'b1;
         valid  <= 1'b0;
         cout_q <= 1'b0;
         idle   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_q   <= bus.in_a;
                  b_q   <= bus.in_b;
                  pipo  <= 1'b1;
                  cclr  <= 1'b0;
                  idle  <= 1'b0;
                  state <= LOAD;
               end
            end
            LOAD: begin
               cnt   <= '0;
               pipo  <= 1'b0;
               cclr  <= 1'b1;
               shift <= 1'b1;
               state <= SHIFT;
            end
            SHIFT: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == LAST) begin
                  cout_q <= bus.dp_cout;
                  shift  <= 1'b0;
                  valid  <= 1'b1;
                  state  <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  valid <= 1'b0;
                  if (bus.in_valid) begin
                     a_q   <= bus.in_a;
                     b_q   <= bus.in_b;
                     pipo  <= 1'b1;
                     cclr  <= 1'b0;
                     state <= LOAD;
                  end else begin
                     idle  <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   sum_deser #(.WIDTH(WIDTH)) u_sum_deser (
      .clk (clk),
      .clr (clr),
      .en  (shift),
      .din (bus.dp_sum),
      .q   (sum_q)
   );

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and randomised checks of serial_add_ctrl against a behavioural datapath.
module tb_serial_add_ctrl;
   import serial_add_pkg::*;

   localparam int W = 4;

   logic clk = 1'b0;
   logic clr = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   serial_add_ctrl_if #(.WIDTH(W)) bus ();

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Behavioural datapath: two operand shift registers and a carry flop
   logic [W-1:0] ra = '0;
   logic [W-1:0] rb = '0;
   logic         c  = 1'b0;

   always @(posedge clk) begin
      if (bus.dp_pipo) begin
         ra <= bus.dp_a;
         rb <= bus.dp_b;
      end else if (bus.dp_shift) begin
         ra <= ra >> 1;
         rb <= rb >> 1;
      end
   end

   always @(posedge clk or negedge bus.dp_cclr) begin
      if (!bus.dp_cclr) c <= 1'b0;
      else if (bus.dp_shift) c <= bus.dp_cout;
   end

   assign bus.dp_sum  = ra[0] ^ rb[0] ^ c;
   assign bus.dp_cout = (ra[0] & rb[0]) | (c & (ra[0] ^ rb[0]));

   // Presents an operand pair until accepted; returns 1ns after the accepting edge
   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output bit ok);
      @(negedge clk);
      bus.in_a = a;
      bus.in_b = b;
      bus.in_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         #1;
         if (bus.in_ready) ok = 1'b1;
         else @(negedge clk);
      end
      if (ok) @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_a = ~a;
      bus.in_b = ~b;
   endtask

   // Edges counted from and including the accepting edge until out_valid is seen
   task automatic wait_valid(output int edges);
      edges = 1;
      while (!bus.out_valid && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
   endtask

   task automatic take();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      vectors++;
      if ({bus.out_valid, bus.dp_pipo, bus.dp_shift, bus.dp_cclr, bus.busy} !== 5'b00010) begin
         miscompares++;
         $display("FAIL reset_ctrl: got valid/pipo/shift/cclr/busy=%b want 00010",
                  {bus.out_valid, bus.dp_pipo, bus.dp_shift, bus.dp_cclr, bus.busy});
      end
      vectors++;
      if ({bus.out_cout, bus.out_sum, bus.dp_a, bus.dp_b} !== '0) begin
         miscompares++;
         $display("FAIL reset_data: got cout=%b sum=%h dp_a=%h dp_b=%h want all 0",
                  bus.out_cout, bus.out_sum, bus.dp_a, bus.dp_b);
      end
      @(negedge clk);
      clr = 1'b1;
      #1;
      vectors++;
      if (bus.in_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
      end
   endtask

   task automatic test_basic();
      bit ok;
      int edges;
      send(4'b0100, 4'b0001, ok);
      vectors++;
      if (ok !== 1'b1) begin
         miscompares++;
         $display("FAIL basic_accept: got %b want 1", ok);
      end
      wait_valid(edges);
      vectors++;
      if (edges !== W + 2) begin
         miscompares++;
         $display("FAIL basic_latency: got %0d want %0d", edges, W + 2);
      end
      vectors++;
      if ({bus.out_cout, bus.out_sum} !== 5'b0_0101) begin
         miscompares++;
         $display("FAIL basic_result: got %b want 00101", {bus.out_cout, bus.out_sum});
      end
      vectors++;
      if ({bus.in_ready, bus.busy} !== 2'b01) begin
         miscompares++;
         $display("FAIL basic_done_flags: got ready/busy=%b want 01", {bus.in_ready, bus.busy});
      end
      take();
      vectors++;
      if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001) begin
         miscompares++;
         $display("FAIL basic_release: got valid/busy/ready=%b want 001",
                  {bus.out_valid, bus.busy, bus.in_ready});
      end
   endtask

   task automatic test_carry();
      bit ok;
      int edges;
      send(4'b1111, 4'b0001, ok);
      vectors++;
      if ({ok, bus.dp_pipo, bus.dp_cclr, bus.dp_shift, bus.in_ready, bus.busy} !== 6'b110001) begin
         miscompares++;
         $display("FAIL carry_load: got ok/pipo/cclr/shift/ready/busy=%b want 110001",
                  {ok, bus.dp_pipo, bus.dp_cclr, bus.dp_shift, bus.in_ready, bus.busy});
      end
      wait_valid(edges);
      vectors++;
      if ({bus.out_cout, bus.out_sum} !== 5'b1_0000) begin
         miscompares++;
         $display("FAIL carry_result: got %b want 10000", {bus.out_cout, bus.out_sum});
      end
      take();
      // Carry flop is left at 1 here; the next op must not see it
      send(4'b0100, 4'b0001, ok);
      wait_valid(edges);
      vectors++;
      if ({bus.out_cout, bus.out_sum} !== 5'b0_0101) begin
         miscompares++;
         $display("FAIL carry_stale: got %b want 00101", {bus.out_cout, bus.out_sum});
      end
      take();
   endtask

   task automatic test_back_to_back();
      bit ok;
      int edges;
      int bad;
      send(4'b0101, 4'b0011, ok);
      wait_valid(edges);
      @(negedge clk);
      bus.in_a = 4'b0100;
      bus.in_b = 4'b0010;
      bus.in_valid = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      vectors++;
      if ({bus.in_ready, bus.out_valid, bus.out_cout, bus.out_sum} !== 7'b11_0_1000) begin
         miscompares++;
         $display("FAIL b2b_first: got ready/valid/cout/sum=%b want 1101000",
                  {bus.in_ready, bus.out_valid, bus.out_cout, bus.out_sum});
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.in_a = 4'b1111;
      bus.in_b = 4'b1111;
      vectors++;
      if ({bus.dp_pipo, bus.out_valid} !== 2'b10) begin
         miscompares++;
         $display("FAIL b2b_direct_load: got pipo/valid=%b want 10", {bus.dp_pipo, bus.out_valid});
      end
      bad = 0;
      edges = 1;
      while (!bus.out_valid && edges < 40) begin
         if (bus.in_ready) bad++;
         @(posedge clk);
         #1;
         edges++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL b2b_in_ready_busy: got %0d cycles with in_ready high want 0", bad);
      end
      vectors++;
      if (edges !== W + 2) begin
         miscompares++;
         $display("FAIL b2b_latency: got %0d want %0d", edges, W + 2);
      end
      vectors++;
      if ({bus.out_cout, bus.out_sum} !== 5'b0_0110) begin
         miscompares++;
         $display("FAIL b2b_second: got %b want 00110", {bus.out_cout, bus.out_sum});
      end
      take();
   endtask

   task automatic test_stall();
      bit ok;
      int edges;
      int bad;
      send(4'b1010, 4'b0111, ok);
      wait_valid(edges);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!bus.out_valid || bus.out_sum !== 4'b0001 || bus.out_cout !== 1'b1 ||
             bus.dp_shift || bus.dp_pipo) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL stall_hold: got %0d unstable cycles want 0", bad);
      end
      vectors++;
      if ({bus.out_valid, bus.out_cout, bus.out_sum} !== 6'b1_1_0001) begin
         miscompares++;
         $display("FAIL stall_result: got valid/cout/sum=%b want 110001",
                  {bus.out_valid, bus.out_cout, bus.out_sum});
      end
      take();
   endtask

   task automatic test_midop_reset();
      bit ok;
      int edges;
      int bad;
      send(4'b0011, 4'b0101, ok);
      @(posedge clk);
      @(posedge clk);
      #3;
      vectors++;
      if (bus.dp_shift !== 1'b1) begin
         miscompares++;
         $display("FAIL rst_pre_shift: got %b want 1", bus.dp_shift);
      end
      clr = 1'b0;
      #1;
      vectors++;
      if ({bus.out_valid, bus.dp_pipo, bus.dp_shift, bus.dp_cclr, bus.busy, bus.out_cout} !== 6'b000100) begin
         miscompares++;
         $display("FAIL rst_mid_ctrl: got valid/pipo/shift/cclr/busy/cout=%b want 000100",
                  {bus.out_valid, bus.dp_pipo, bus.dp_shift, bus.dp_cclr, bus.busy, bus.out_cout});
      end
      vectors++;
      if ({bus.out_sum, bus.dp_a, bus.dp_b} !== '0) begin
         miscompares++;
         $display("FAIL rst_mid_data: got sum=%h dp_a=%h dp_b=%h want 0", bus.out_sum, bus.dp_a, bus.dp_b);
      end
      @(negedge clk);
      clr = 1'b1;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (bus.out_valid || bus.busy) bad++;
      end
      vectors++;
      if (bad !== 0) begin
         miscompares++;
         $display("FAIL rst_no_result: got %0d cycles valid/busy want 0", bad);
      end
      send(4'b1001, 4'b1000, ok);
      wait_valid(edges);
      vectors++;
      if ({bus.out_cout, bus.out_sum} !== 5'b1_0001) begin
         miscompares++;
         $display("FAIL rst_after_op: got %b want 10001", {bus.out_cout, bus.out_sum});
      end
      take();
   endtask

   task automatic test_random();
      logic [W:0]   exp_q[$];
      logic [W:0]   e;
      logic [W-1:0] a;
      logic [W-1:0] b;
      int sent = 0;
      int got = 0;
      int cyc = 0;
      bit fired = 1'b0;
      a = '0;
      b = '0;
      while ((sent < 200 || got < sent) && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (fired) bus.in_valid = 1'b0;
         fired = 1'b0;
         if (!bus.in_valid) begin
            if (sent < 200 && $urandom_range(0, 3) != 0) begin
               a = W'($urandom);
               b = W'($urandom);
               bus.in_a = a;
               bus.in_b = b;
               bus.in_valid = 1'b1;
            end else begin
               bus.in_a = W'($urandom);
               bus.in_b = W'($urandom);
            end
         end
         bus.out_ready = ($urandom_range(0, 2) != 0);
         #1;
         if (bus.out_valid && bus.out_ready) begin
            got++;
            vectors++;
            if (exp_q.size() == 0) begin
               miscompares++;
               $display("FAIL rand_extra: got result %b with none outstanding", {bus.out_cout, bus.out_sum});
            end else begin
               e = exp_q.pop_front();
               if ({bus.out_cout, bus.out_sum} !== e) begin
                  miscompares++;
                  $display("FAIL rand_result: got %b want %b", {bus.out_cout, bus.out_sum}, e);
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back({1'b0, a} + {1'b0, b});
            sent++;
            fired = 1'b1;
         end
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      vectors++;
      if (sent != 200 || got != 200 || exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL rand_count: got sent=%0d done=%0d pending=%0d want 200/200/0",
                  sent, got, exp_q.size());
      end
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.in_a = '0;
      bus.in_b = '0;
      bus.out_ready = 1'b0;
      clr = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_basic();
      test_carry();
      test_back_to_back();
      test_stall();
      test_midop_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
